// File: rtl/pulse_window_ctrl.sv
// Windowed pulse counter keeping a 4-deep history for the avg_4 datapath.
// Define AVG_PRIME_EN to seed the whole history from the first window.
module pulse_window_ctrl #(
    parameter int unsigned WINDOW_CYCLES = 1_500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       clear,
    input  logic       pulse_in,
    input  logic [7:0] pulseavg,
    output logic [7:0] count1,
    output logic [7:0] count2,
    output logic [7:0] count3,
    output logic [7:0] count4,
    output logic [7:0] avg_out,
    output logic       avg_valid,
    output logic [7:0] win_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        UPD
    } state_t;

    localparam logic [30:0] WLAST = 31'(WINDOW_CYCLES - 1);

    state_t      state_q, state_d;
    logic        pulse_q;
    logic [30:0] wcnt_q, wcnt_d;
    logic [7:0]  win_q, win_d;
    logic [7:0]  c1_q, c1_d;
    logic [7:0]  c2_q, c2_d;
    logic [7:0]  c3_q, c3_d;
    logic [7:0]  c4_q, c4_d;
    logic [2:0]  fill_q, fill_d;
    logic [7:0]  avg_q, avg_d;
    logic        valid_q, valid_d;

    logic        rise;
    logic        term;
    logic [7:0]  win_inc;

    assign rise    = pulse_in & ~pulse_q;
    assign term    = (wcnt_q == WLAST);
    assign win_inc = (win_q == 8'hFF) ? win_q : win_q + {7'd0, rise};

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        win_d   = win_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        c3_d    = c3_q;
        c4_d    = c4_q;
        fill_d  = fill_q;
        avg_d   = avg_q;
        valid_d = 1'b0;
        if (clear) begin
            state_d = enable ? ACQ : IDLE;
            wcnt_d  = '0;
            win_d   = '0;
            c1_d    = '0;
            c2_d    = '0;
            c3_d    = '0;
            c4_d    = '0;
            fill_d  = '0;
            avg_d   = '0;
        end else if (!enable) begin
            // dropping enable discards the partial window
            state_d = IDLE;
            wcnt_d  = '0;
            win_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = ACQ;
                ACQ: begin
                    win_d  = win_inc;
                    wcnt_d = wcnt_q + 31'd1;
                    if (term) begin
                        wcnt_d  = '0;
                        win_d   = '0;
                        state_d = UPD;
`ifdef AVG_PRIME_EN
                        if (fill_q == 3'd0) begin
                            c1_d   = win_inc;
                            c2_d   = win_inc;
                            c3_d   = win_inc;
                            c4_d   = win_inc;
                            fill_d = 3'd4;
                        end else begin
                            c4_d   = c3_q;
                            c3_d   = c2_q;
                            c2_d   = c1_q;
                            c1_d   = win_inc;
                            fill_d = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
                        end
`else
                        c4_d   = c3_q;
                        c3_d   = c2_q;
                        c2_d   = c1_q;
                        c1_d   = win_inc;
                        fill_d = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
`endif
                    end
                end
                UPD: begin
                    // avg_4 has settled on the new history by now
                    win_d   = win_inc;
                    wcnt_d  = wcnt_q + 31'd1;
                    state_d = ACQ;
                    if (fill_q == 3'd4) begin
                        avg_d   = pulseavg;
                        valid_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pulse_q <= 1'b0;
            wcnt_q  <= '0;
            win_q   <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
            c3_q    <= '0;
            c4_q    <= '0;
            fill_q  <= '0;
            avg_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_in;
            wcnt_q  <= wcnt_d;
            win_q   <= win_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            c3_q    <= c3_d;
            c4_q    <= c4_d;
            fill_q  <= fill_d;
            avg_q   <= avg_d;
            valid_q <= valid_d;
        end
    end

    assign count1    = c1_q;
    assign count2    = c2_q;
    assign count3    = c3_q;
    assign count4    = c4_q;
    assign avg_out   = avg_q;
    assign avg_valid = valid_q;
    assign win_count = win_q;

endmodule

// File: tb/tb_pulse_window_ctrl.sv
// Bench for pulse_window_ctrl: two instances (10- and 1000-cycle windows)
// checked cycle by cycle against a window-level reference model.
module tb_pulse_window_ctrl;

`ifdef AVG_PRIME_EN
    localparam bit PRIME = 1'b1;
`else
    localparam bit PRIME = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       en[2];
    logic       clr[2];
    logic       pin[2];
    logic [7:0] pa[2];
    logic [7:0] c1[2];
    logic [7:0] c2[2];
    logic [7:0] c3[2];
    logic [7:0] c4[2];
    logic [7:0] ao[2];
    logic       av[2];
    logic [7:0] wc[2];

    int vectors;
    int miscompares;

    int wl[2] = '{10, 1000};
    int m_hist[2][4];
    int m_fill[2];
    int m_live[2];
    int m_pos[2];
    int m_avg[2];
    bit m_run[2];
    bit m_upd[2];
    bit m_val[2];
    bit m_prev[2];

    // avg_4 stand-in: truncating mean of the history
    assign pa[0] = 8'((10'(c1[0]) + 10'(c2[0]) + 10'(c3[0]) + 10'(c4[0])) >> 2);
    assign pa[1] = 8'((10'(c1[1]) + 10'(c2[1]) + 10'(c3[1]) + 10'(c4[1])) >> 2);

    pulse_window_ctrl #(.WINDOW_CYCLES(10)) u0 (
        .clk(clk), .rst_n(rst_n), .enable(en[0]), .clear(clr[0]),
        .pulse_in(pin[0]), .pulseavg(pa[0]),
        .count1(c1[0]), .count2(c2[0]), .count3(c3[0]), .count4(c4[0]),
        .avg_out(ao[0]), .avg_valid(av[0]), .win_count(wc[0])
    );

    pulse_window_ctrl #(.WINDOW_CYCLES(1000)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(en[1]), .clear(clr[1]),
        .pulse_in(pin[1]), .pulseavg(pa[1]),
        .count1(c1[1]), .count2(c2[1]), .count3(c3[1]), .count4(c4[1]),
        .avg_out(ao[1]), .avg_valid(av[1]), .win_count(wc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [48:0] dut_v(input int k);
        return {c1[k], c2[k], c3[k], c4[k], ao[k], av[k], wc[k]};
    endfunction

    function automatic logic [48:0] model_v(input int k);
        return {8'(m_hist[k][0]), 8'(m_hist[k][1]), 8'(m_hist[k][2]),
                8'(m_hist[k][3]), 8'(m_avg[k]), m_val[k], 8'(m_live[k])};
    endfunction

    function automatic logic pat(input int c, input int n);
        return (c % 2 == 1) && (c < 2 * n);
    endfunction

    task automatic model_reset(input int k);
        for (int j = 0; j < 4; j++) m_hist[k][j] = 0;
        m_fill[k] = 0; m_live[k] = 0; m_pos[k] = 0; m_avg[k] = 0;
        m_run[k] = 0; m_upd[k] = 0; m_val[k] = 0; m_prev[k] = 0;
    endtask

    task automatic close_window(input int k);
        int f = m_live[k];
        if (PRIME && m_fill[k] == 0) begin
            for (int j = 0; j < 4; j++) m_hist[k][j] = f;
            m_fill[k] = 4;
        end else begin
            for (int j = 3; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
            m_hist[k][0] = f;
            if (m_fill[k] < 4) m_fill[k]++;
        end
        m_live[k] = 0;
        m_pos[k]  = 0;
        m_upd[k]  = 1;
    endtask

    task automatic tick(input int k);
        bit e;
        if (!rst_n) begin
            model_reset(k);
            return;
        end
        e = pin[k] && !m_prev[k];
        m_prev[k] = pin[k];
        m_val[k] = 0;
        if (clr[k]) begin
            for (int j = 0; j < 4; j++) m_hist[k][j] = 0;
            m_fill[k] = 0; m_live[k] = 0; m_pos[k] = 0; m_avg[k] = 0;
            m_run[k] = en[k]; m_upd[k] = 0;
        end else if (!en[k]) begin
            m_run[k] = 0; m_pos[k] = 0; m_live[k] = 0; m_upd[k] = 0;
        end else if (!m_run[k]) begin
            m_run[k] = 1;
        end else begin
            if (m_upd[k] && m_fill[k] == 4) begin
                m_avg[k] = (m_hist[k][0] + m_hist[k][1]
                          + m_hist[k][2] + m_hist[k][3]) >> 2;
                m_val[k] = 1;
            end
            m_upd[k] = 0;
            m_live[k] = (m_live[k] + e > 255) ? 255 : m_live[k] + e;
            if (m_pos[k] == wl[k] - 1) close_window(k);
            else m_pos[k]++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        tick(0);
        tick(1);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (dut_v(k) !== 49'd0) begin
                miscompares++;
                $display("FAIL reset_state inst%0d: got %h want 0", k, dut_v(k));
            end
        end
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (dut_v(k) !== model_v(k)) begin
                miscompares++;
                $display("FAIL after_reset inst%0d: got %h want %h",
                         k, dut_v(k), model_v(k));
            end
        end
    endtask

    task automatic test_four_windows();
        int nval = 0;
        en[0] = 0; clr[0] = 1; step();
        clr[0] = 0; en[0] = 1; step();
        for (int w = 0; w < 4; w++) begin
            for (int c = 0; c < 10; c++) begin
                pin[0] = pat(c, 3);
                step();
                if (av[0]) nval++;
                vectors++;
                if (dut_v(0) !== model_v(0)) begin
                    miscompares++;
                    $display("FAIL four_win: got %h want %h", dut_v(0), model_v(0));
                end
            end
        end
        pin[0] = 0;
        step();
        if (av[0]) nval++;
        vectors++;
        if (nval !== (PRIME ? 4 : 1)) begin
            miscompares++;
            $display("FAIL four_win_nvalid: got %0d want %0d", nval, PRIME ? 4 : 1);
        end
        vectors++;
        if ({c1[0], c2[0], c3[0], c4[0]} !== {4{8'd3}}) begin
            miscompares++;
            $display("FAIL four_win_hist: got %h want 03030303",
                     {c1[0], c2[0], c3[0], c4[0]});
        end
        vectors++;
        if (ao[0] !== 8'd3 || av[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL four_win_avg: got %0d/%b want 3/1", ao[0], av[0]);
        end
        step();
        vectors++;
        if (av[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL four_win_strobe: got %b want 0", av[0]);
        end
    endtask

    task automatic test_known_counts();
        int cnts[5] = '{10, 20, 30, 41, 0};
        int seen[$];
        en[1] = 0; clr[1] = 1; step();
        clr[1] = 0; en[1] = 1; step();
        for (int w = 0; w < 5; w++) begin
            for (int c = 0; c < 1000; c++) begin
                pin[1] = pat(c, cnts[w]);
                step();
                if (av[1]) seen.push_back(int'(ao[1]));
                vectors++;
                if (dut_v(1) !== model_v(1)) begin
                    miscompares++;
                    $display("FAIL known_counts: got %h want %h", dut_v(1), model_v(1));
                end
            end
        end
        pin[1] = 0;
        step();
        if (av[1]) seen.push_back(int'(ao[1]));
        vectors++;
        if (seen.size() != (PRIME ? 5 : 2)) begin
            miscompares++;
            $display("FAIL known_nvalid: got %0d want %0d", seen.size(), PRIME ? 5 : 2);
        end else begin
            vectors++;
            if (seen[seen.size()-2] != 25) begin
                miscompares++;
                $display("FAIL known_avg25: got %0d want 25", seen[seen.size()-2]);
            end
            vectors++;
            if (seen[seen.size()-1] != 22) begin
                miscompares++;
                $display("FAIL known_avg22: got %0d want 22", seen[seen.size()-1]);
            end
        end
        en[1] = 0;
        step();
    endtask

    task automatic test_saturation();
        en[1] = 0; clr[1] = 1; step();
        clr[1] = 0; en[1] = 1; step();
        for (int c = 0; c < 1000; c++) begin
            pin[1] = pat(c, 300);
            step();
            vectors++;
            if (dut_v(1) !== model_v(1)) begin
                miscompares++;
                $display("FAIL saturate: got %h want %h", dut_v(1), model_v(1));
            end
            if (c == 998) begin
                vectors++;
                if (wc[1] !== 8'd255) begin
                    miscompares++;
                    $display("FAIL sat_win_count: got %0d want 255", wc[1]);
                end
            end
        end
        vectors++;
        if (c1[1] !== 8'd255 || wc[1] !== 8'd0) begin
            miscompares++;
            $display("FAIL sat_count1: got %0d/%0d want 255/0", c1[1], wc[1]);
        end
        pin[1] = 0; en[1] = 0;
        step();
    endtask

    task automatic test_edge_boundary();
        en[0] = 0; clr[0] = 1; step();
        clr[0] = 0; en[0] = 1; step();
        for (int w = 0; w < 3; w++) begin
            for (int c = 0; c < 10; c++) begin
                pin[0] = (w == 0 && c == 9) || (w == 2 && c == 0);
                step();
                vectors++;
                if (dut_v(0) !== model_v(0)) begin
                    miscompares++;
                    $display("FAIL edge_bound: got %h want %h", dut_v(0), model_v(0));
                end
                if (w == 0 && c == 9) begin
                    vectors++;
                    if (c1[0] !== 8'd1 || wc[0] !== 8'd0) begin
                        miscompares++;
                        $display("FAIL term_edge: got %0d/%0d want 1/0", c1[0], wc[0]);
                    end
                end
                if (w == 2 && c == 0) begin
                    vectors++;
                    if (wc[0] !== 8'd1) begin
                        miscompares++;
                        $display("FAIL upd_edge: got %0d want 1", wc[0]);
                    end
                end
            end
        end
        pin[0] = 0;
    endtask

    task automatic test_reset_clear_mid();
        for (int m = 0; m < 2; m++) begin
            int nval = 0;
            en[0] = 0; clr[0] = 1; step();
            clr[0] = 0; en[0] = 1; step();
            for (int i = 0; i < 26; i++) begin
                pin[0] = pat(i % 10, 3);
                step();
            end
            pin[0] = 0;
            if (m == 0) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset(0);
                model_reset(1);
                for (int k = 0; k < 2; k++) begin
                    vectors++;
                    if (dut_v(k) !== 49'd0) begin
                        miscompares++;
                        $display("FAIL async_rst inst%0d: got %h want 0", k, dut_v(k));
                    end
                end
                step();
                rst_n = 1'b1;
                step();
            end else begin
                clr[0] = 1;
                step();
                clr[0] = 0;
                vectors++;
                if (dut_v(0) !== 49'd0) begin
                    miscompares++;
                    $display("FAIL sync_clr: got %h want 0", dut_v(0));
                end
            end
            for (int w = 0; w < 4; w++) begin
                for (int c = 0; c < 10; c++) begin
                    pin[0] = pat(c, 3);
                    step();
                    if (av[0]) nval++;
                    vectors++;
                    if (dut_v(0) !== model_v(0)) begin
                        miscompares++;
                        $display("FAIL refill m%0d: got %h want %h",
                                 m, dut_v(0), model_v(0));
                    end
                end
            end
            pin[0] = 0;
            step();
            if (av[0]) nval++;
            vectors++;
            if (nval !== (PRIME ? 4 : 1) || av[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL refill_valid m%0d: got %0d/%b want %0d/1",
                         m, nval, av[0], PRIME ? 4 : 1);
            end
        end
    endtask

    task automatic test_first_window();
        logic [48:0] exp;
        en[1] = 0; clr[1] = 1; step();
        clr[1] = 0; en[1] = 1; step();
        for (int c = 0; c < 1000; c++) begin
            pin[1] = pat(c, 7);
            step();
        end
        pin[1] = 0;
        step();
        exp = PRIME ? {8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 1'b1, 8'd0}
                    : {8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0};
        vectors++;
        if (dut_v(1) !== exp) begin
            miscompares++;
            $display("FAIL first_window: got %h want %h", dut_v(1), exp);
        end
        en[1] = 0;
        step();
    endtask

    task automatic test_random();
        for (int k = 0; k < 2; k++) en[k] = 1;
        for (int i = 0; i < 6000; i++) begin
            for (int k = 0; k < 2; k++) begin
                pin[k] = 1'($urandom_range(0, 1));
                en[k]  = ($urandom_range(0, 199) != 0);
                clr[k] = ($urandom_range(0, 299) == 0);
            end
            step();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (dut_v(k) !== model_v(k)) begin
                    miscompares++;
                    $display("FAIL random inst%0d cyc%0d: got %h want %h",
                             k, i, dut_v(k), model_v(k));
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            pin[k] = 0; clr[k] = 0; en[k] = 0;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            en[k] = 0; clr[k] = 0; pin[k] = 0;
            model_reset(k);
        end
        test_reset();
        test_four_windows();
        test_known_counts();
        test_saturation();
        test_edge_boundary();
        test_reset_clear_mid();
        test_first_window();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pulse_window_ctrl.md
# pulse_window_ctrl

Sequencing controller for the pulse monitor's 4-sample averager. It counts pulse edges over fixed time windows and keeps the last four window counts in a shift history. The history drives the external `avg_4` adder/shift datapath; the controller latches the averaged result once per window and flags it with a one-cycle valid strobe. It sits between the synchronized pulse-sensor input and the display/BPM logic.

## Interface
- `WINDOW_CYCLES`, default 1_500_000_000: clock cycles per counting window (15 s at 100 MHz); legal range 2 to 2^31-1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `enable`  in  1  run control; low holds the block in IDLE.
- `clear`  in  1  synchronous flush of the counters, the history and `avg_out`.
- `pulse_in`  in  1  pulse level, already synchronized to `clk`; each rising edge is one pulse.
- `pulseavg`  in  8  result returned from `avg_4`.
- `count1..count4`  out  8 each  history to `avg_4`; `count1` is the newest window, `count4` the oldest.
- `avg_out`  out  8  latched average.
- `avg_valid`  out  1  one-cycle strobe when `avg_out` updates.
- `win_count`  out  8  live count of the current window.

## Operation
- Reset value of all outputs and internal registers is 0; state is IDLE.
- Edge detect: `pulse_in` is high and the previous `pulse_in` sample is low. The sample register resets to 0.
- `win_count` saturates at 255 and does not wrap.
- The window counter runs 0..WINDOW_CYCLES-1 while the state is ACQ or UPD, then wraps to 0.
- The terminal cycle is the cycle in which the window counter equals WINDOW_CYCLES-1.
- **IDLE**
  - Window counter and `win_count` are held at 0; the history is retained.
  - Moves to ACQ when `enable` = 1.
- **ACQ**
  - Counts edges.
  - On the terminal cycle:
    - `count4`←`count3`, `count3`←`count2`, `count2`←`count1`, `count1`←final window count. The final window count includes an edge in the terminal cycle.
    - `win_count`←0.
    - `fill_cnt` increments, saturating at 4.
    - Next state is UPD.
- **UPD** (exactly 1 cycle)
  - Edge counting continues into the new window.
  - If `fill_cnt` = 4: `avg_out`←`pulseavg` and `avg_valid`=1 on the next cycle.
  - Next state is ACQ.
- `enable` falling, from any state: next state is IDLE and `avg_valid` is suppressed. A partially counted window is discarded.
- `clear` has priority over everything except `rst_n`. It zeroes the history, `fill_cnt`, `win_count`, the window counter and `avg_out`, and the next state is IDLE if `enable` = 0, otherwise ACQ.
- `pulseavg` arithmetic is owned by `avg_4`: a 10-bit sum shifted right by 2, i.e. truncating. The controller neither recomputes nor rounds it.

## Timing
- Terminal cycle T: the history registers change at the end of T.
- T+1 is UPD. `avg_4` settles combinationally from the new history and `pulseavg` is sampled at the end of T+1.
- In T+2, `avg_out` holds the new value and `avg_valid`=1 for exactly one cycle.
- Latency from the last pulse of a window to `avg_valid`: at most WINDOW_CYCLES+1 cycles.
- `avg_valid` spacing is exactly WINDOW_CYCLES cycles in steady state.
- `rst_n` asserted mid-window: all state clears immediately; counting restarts from cycle 0 after release.

## Configuration
- `AVG_PRIME_EN` defined:
  - On the first terminal cycle after reset/clear (`fill_cnt` = 0), the final count is written to all four history slots and `fill_cnt` is set to 4.
  - `avg_valid` therefore fires after the first window.
- Not defined:
  - Normal shifting applies and `fill_cnt` increments by one per window.
  - The first `avg_valid` comes after the fourth window.

## Test plan
- WINDOW_CYCLES=10, macro off, 3 edges in each of the first four windows:
  - no `avg_valid` in windows 1–3;
  - after window 4, `count1..4`=3,3,3,3, `avg_out`=3, with `avg_valid` one cycle at T+2.
- Window counts 10, 20, 30, 41 → `avg_out`=25 (101>>2). A fifth window of 0 → 22 (91>>2).
- 300 edges in one window (WINDOW_CYCLES=1000): `win_count` sticks at 255 and `count1`=255.
- Edge exactly on the terminal cycle: counted in the closing window. Edge in the UPD cycle: `win_count`=1 in the new window.
- Reset and clear mid-window:
  - `rst_n` low at cycle 5 of window 3: all outputs 0 asynchronously, and a full 4-window refill is needed before `avg_valid`;
  - `clear` pulse gives the same result, synchronously.
- Macro on, 7 edges in the first window: `count1..4`=7,7,7,7, `avg_out`=7, and `avg_valid` fires after window 1.
